// File: rtl/rom_bus_fetch_pkg.sv
// Shared types and constants for the cartridge ROM bus-fetch stage.
package rom_bus_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    CAPTURE = 3'd2,
    DRIVE   = 3'd3,
    HOLD    = 3'd4
  } state_t;

  localparam logic [15:0] DEF_WIN_BASE      = 16'hD000;
  localparam logic [15:0] DEF_BANK_REG_ADDR = 16'hC0F0;

  function automatic int unsigned rom_aw(input int unsigned bank_w, input int unsigned win_aw);
    return bank_w + win_aw;
  endfunction

endpackage

// File: rtl/rom_bus_fetch_sync_ff.sv
// Multi-flop synchroniser for a single asynchronous control bit.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/rom_bus_fetch.sv
// Bridges the asynchronous 6502 slot-bus strobe to a registered-read ROM and
// hosts the write-only bank-select register.
module rom_bus_fetch
  import rom_bus_fetch_pkg::*;
#(
  parameter int unsigned DW            = 8,
  parameter int unsigned WIN_AW        = 12,
  parameter int unsigned BANK_W        = 2,
  parameter logic [15:0] WIN_BASE      = DEF_WIN_BASE,
  parameter logic [15:0] BANK_REG_ADDR = DEF_BANK_REG_ADDR,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic                                  bus_sel,
  input  logic                                  bus_rw,
  input  logic [15:0]                           bus_a,
  input  logic [DW-1:0]                         bus_d_in,
  output logic [DW-1:0]                         bus_d_out,
  output logic                                  bus_d_oe,
  output logic                                  rom_ce,
  output logic [rom_aw(BANK_W, WIN_AW)-1:0]     rom_a,
  input  logic [DW-1:0]                         rom_d,
  output logic [BANK_W-1:0]                     bank
);

  localparam int unsigned RAW = rom_aw(BANK_W, WIN_AW);

  state_t          state, state_d;
  logic            sel_s, sel_s_q;
  logic            rise, fall;
  logic            win_hit, bank_hit;
  logic            rom_ce_d, oe_d;
  logic [RAW-1:0]  rom_a_d;
  logic [BANK_W-1:0] bank_d;
  logic [DW-1:0]   dout_d;
  logic            unused_d_in;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sel_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (bus_sel),
    .q       (sel_s)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sel_s_q <= 1'b0;
    end else begin
      sel_s_q <= sel_s;
    end
  end

  assign rise = sel_s & ~sel_s_q;
  assign fall = ~sel_s & sel_s_q;

  // Address and data are only consulted on the rise cycle, when the bus has long been stable.
  assign win_hit     = (bus_a[15:WIN_AW] == WIN_BASE[15:WIN_AW]);
  assign bank_hit    = (bus_a == BANK_REG_ADDR);
  assign unused_d_in = ^bus_d_in[DW-1:BANK_W];

  always_comb begin
    state_d  = state;
    rom_ce_d = 1'b0;
    rom_a_d  = rom_a;
    bank_d   = bank;
    dout_d   = bus_d_out;
    oe_d     = bus_d_oe;
    case (state)
      IDLE: begin
        if (rise) begin
          if (bus_rw && win_hit) begin
            rom_a_d  = {bank, bus_a[WIN_AW-1:0]};
            rom_ce_d = 1'b1;
            state_d  = ISSUE;
          end else begin
            if (!bus_rw && bank_hit) begin
              bank_d = bus_d_in[BANK_W-1:0];
            end
            state_d = HOLD;
          end
        end
      end
      ISSUE: begin
        state_d = sel_s ? CAPTURE : IDLE;
      end
      CAPTURE: begin
        if (sel_s) begin
          dout_d  = rom_d;
          oe_d    = 1'b1;
          state_d = DRIVE;
        end else begin
          state_d = IDLE;
        end
      end
      DRIVE: begin
        if (fall) begin
          oe_d    = 1'b0;
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (fall) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rom_ce    <= 1'b0;
      rom_a     <= '0;
      bank      <= '0;
      bus_d_out <= '0;
      bus_d_oe  <= 1'b0;
    end else begin
      state     <= state_d;
      rom_ce    <= rom_ce_d;
      rom_a     <= rom_a_d;
      bank      <= bank_d;
      bus_d_out <= dout_d;
      bus_d_oe  <= oe_d;
    end
  end

endmodule

// File: tb/tb_rom_bus_fetch.sv
// Directed self-checking bench for rom_bus_fetch with a registered-read ROM model.
module tb_rom_bus_fetch;

  localparam int unsigned SYNC_STAGES = 2;
  // Edge 1 is the first clock edge to sample bus_sel; oe rises SYNC_STAGES+2 edges later.
  localparam int OE_EDGE = SYNC_STAGES + 3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        bus_sel = 1'b0;
  logic        bus_rw = 1'b1;
  logic [15:0] bus_a = '0;
  logic [7:0]  bus_d_in = '0;
  logic [7:0]  bus_d_out;
  logic        bus_d_oe;
  logic        rom_ce;
  logic [13:0] rom_a;
  logic [7:0]  rom_d = '0;
  logic [1:0]  bank;

  logic [7:0]  mem [0:16383];
  int          checks = 0;
  int          errors = 0;
  int          ce_count = 0;
  logic [13:0] ce_addr = '0;

  rom_bus_fetch #(
    .DW            (8),
    .WIN_AW        (12),
    .BANK_W        (2),
    .WIN_BASE      (16'hD000),
    .BANK_REG_ADDR (16'hC0F0),
    .SYNC_STAGES   (SYNC_STAGES)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus_sel   (bus_sel),
    .bus_rw    (bus_rw),
    .bus_a     (bus_a),
    .bus_d_in  (bus_d_in),
    .bus_d_out (bus_d_out),
    .bus_d_oe  (bus_d_oe),
    .rom_ce    (rom_ce),
    .rom_a     (rom_a),
    .rom_d     (rom_d),
    .bank      (bank)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (rom_ce) rom_d <= mem[rom_a];
  end

  always @(negedge clock) begin
    if (rom_ce) begin
      ce_count = ce_count + 1;
      ce_addr  = rom_a;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One strobe: high across `hi` sampling edges, then low for `settle` edges.
  task automatic bus_cycle(input string tag, input logic [15:0] a, input logic rw,
                           input logic [7:0] din, input int hi, input int settle,
                           input int exp_oe_edge, input logic [7:0] exp_d,
                           input int exp_ce, input logic [13:0] exp_rom_a);
    int         first_oe;
    int         ce0;
    logic       low_seen;
    logic [7:0] seen_d;
    ce0      = ce_count;
    first_oe = 0;
    low_seen = 1'b0;
    @(posedge clock); #2;
    bus_a    = a;
    bus_rw   = rw;
    bus_d_in = din;
    bus_sel  = 1'b1;
    for (int e = 1; e <= hi; e++) begin
      @(posedge clock); #1;
      if (!bus_d_oe) low_seen = 1'b1;
      else if (low_seen && first_oe == 0) first_oe = e;
    end
    seen_d = bus_d_out;
    #1 bus_sel = 1'b0;
    check_val({tag, "_oe_edge"}, first_oe, exp_oe_edge);
    if (exp_oe_edge != 0) check_val({tag, "_data"}, seen_d, exp_d);
    repeat (settle) @(posedge clock);
    #1;
    check_val({tag, "_ce_pulses"}, ce_count - ce0, exp_ce);
    if (exp_ce != 0) check_val({tag, "_rom_a"}, ce_addr, exp_rom_a);
    if (settle >= 4) begin
      check_val({tag, "_oe_after"}, bus_d_oe, 1'b0);
      if (exp_oe_edge != 0) check_val({tag, "_dout_hold"}, bus_d_out, exp_d);
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'(i) ^ 8'(i >> 6);
    mem[14'h0123] = 8'hA5;
    mem[14'h0000] = 8'h11;
    mem[14'h0001] = 8'h22;
    mem[14'h3FFF] = 8'h5A;

    #12;
    check_val("rst_oe", bus_d_oe, 1'b0);
    check_val("rst_ce", rom_ce, 1'b0);
    check_val("rst_rom_a", rom_a, 14'h0);
    check_val("rst_bank", bank, 2'b00);
    check_val("rst_dout", bus_d_out, 8'h00);
    @(posedge clock); #3 reset_n = 1'b1;
    repeat (2) @(posedge clock);

    bus_cycle("rd_bank0", 16'hD123, 1'b1, 8'h00, 10, 6, OE_EDGE, 8'hA5, 1, 14'h0123);

    bus_cycle("b2b_0", 16'hD000, 1'b1, 8'h00, 10, 0, OE_EDGE, 8'h11, 1, 14'h0000);
    bus_cycle("b2b_1", 16'hD001, 1'b1, 8'h00, 10, 6, OE_EDGE, 8'h22, 1, 14'h0001);

    bus_cycle("out_win", 16'hE000, 1'b1, 8'h00, 10, 6, 0, 8'h00, 0, 14'h0);

    // Two sampled edges: the ROM is strobed but the strobe is gone before CAPTURE.
    bus_cycle("short", 16'hD123, 1'b1, 8'h00, 2, 6, 0, 8'h00, 1, 14'h0123);
    bus_cycle("after_short", 16'hD123, 1'b1, 8'h00, 10, 6, OE_EDGE, 8'hA5, 1, 14'h0123);

    bus_cycle("bank_wr", 16'hC0F0, 1'b0, 8'h03, 8, 6, 0, 8'h00, 0, 14'h0);
    check_val("bank_val", bank, 2'b11);
    bus_cycle("rd_bank3", 16'hDFFF, 1'b1, 8'h00, 10, 6, OE_EDGE, 8'h5A, 1, 14'h3FFF);
    check_val("rom_a_max", rom_a, 14'h3FFF);

    @(posedge clock); #2;
    bus_a   = 16'hDFFF;
    bus_rw  = 1'b1;
    bus_sel = 1'b1;
    repeat (OE_EDGE + 1) @(posedge clock);
    #1;
    check_val("pre_rst_oe", bus_d_oe, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check_val("mid_rst_oe", bus_d_oe, 1'b0);
    check_val("mid_rst_ce", rom_ce, 1'b0);
    check_val("mid_rst_bank", bank, 2'b00);
    check_val("mid_rst_dout", bus_d_out, 8'h00);
    check_val("mid_rst_rom_a", rom_a, 14'h0);
    bus_sel = 1'b0;
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    repeat (2) @(posedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
